sevenseg_capture: RTL and testbench

Receive-side counterpart of the team's hex-to-seven-segment encoder. Monitors a time-multiplexed NDIG-digit seven-segment bus (segment lines plus one-hot digit enables) and decodes each digit's pattern back to a 4-bit hex value. Publishes the assembled word only after every digit has read back identically over several scans. Used as an on-chip display checker/loopback monitor beside the display driver.

---
 rtl/sevenseg_pkg.sv | 20 ++
 rtl/sevenseg_decode.sv | 33 +++
 rtl/sevenseg_capture.sv | 106 ++++++++++
 tb/tb_sevenseg_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment glyph table (bit6=a .. bit0=g, active-high).
// The display encoder and the capture decoder both draw from these constants.
package sevenseg_pkg;
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h73;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;
endpackage

// File: rtl/sevenseg_decode.sv
// Combinational inverse of the seven-segment encoder. Any pattern outside the
// sixteen glyphs (blank included) reports ok=0.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] segments,
    output logic [3:0] data,
    output logic       ok
);
    always_comb begin
        data = 4'h0;
        ok   = 1'b1;
        case (segments)
            SEG_0: data = 4'h0;
            SEG_1: data = 4'h1;
            SEG_2: data = 4'h2;
            SEG_3: data = 4'h3;
            SEG_4: data = 4'h4;
            SEG_5: data = 4'h5;
            SEG_6: data = 4'h6;
            SEG_7: data = 4'h7;
            SEG_8: data = 4'h8;
            SEG_9: data = 4'h9;
            SEG_A: data = 4'hA;
            SEG_B: data = 4'hB;
            SEG_C: data = 4'hC;
            SEG_D: data = 4'hD;
            SEG_E: data = 4'hE;
            SEG_F: data = 4'hF;
            default: ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/sevenseg_capture.sv
// Monitors a multiplexed seven-segment bus, decodes each digit and publishes
// the assembled hex word once every digit has read back stably.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int NDIG         = 4,
    parameter int SETTLE       = 2,
    parameter int STABLE_SCANS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        segments,
    input  logic [NDIG-1:0]   digit_en,
    output logic [4*NDIG-1:0] value,
    output logic              value_valid,
    output logic [NDIG-1:0]   digit_err
);
    localparam int DW = $clog2(SETTLE + 1);
    localparam int CW = $clog2(STABLE_SCANS + 1);

    logic [6:0]        segs_q;
    logic [NDIG-1:0]   en_q;
    logic [NDIG-1:0]   en_prev;
    logic [DW-1:0]     dwell;
    logic              one_hot;
    logic              strobe;
    logic [3:0]        dec_data;
    logic              dec_ok;
    logic [NDIG-1:0]   stable;
    logic [4*NDIG-1:0] candidate;
    logic              published;
    logic              publish;

    always_ff @(posedge clk) begin
        if (reset) begin
            segs_q  <= '0;
            en_q    <= '0;
            en_prev <= '0;
            dwell   <= '0;
        end else begin
            segs_q  <= segments;
            en_q    <= digit_en;
            en_prev <= en_q;
            if (en_q != en_prev)
                dwell <= '0;
            else if (dwell != DW'(SETTLE))
                dwell <= dwell + 1'b1;
        end
    end

    // Saturation at SETTLE keeps the strobe to one cycle per dwell.
    assign one_hot = (en_q != '0) && ((en_q & (en_q - NDIG'(1))) == '0);
    assign strobe  = one_hot && (en_q == en_prev) && (dwell == DW'(SETTLE - 1));

    sevenseg_decode u_decode (
        .segments(segs_q),
        .data    (dec_data),
        .ok      (dec_ok)
    );

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        logic [3:0]    last;
        logic [CW-1:0] cnt;
        logic          err;

        always_ff @(posedge clk) begin
            if (reset) begin
                last <= '0;
                cnt  <= '0;
                err  <= 1'b0;
            end else if (strobe && en_q[i]) begin
                if (!dec_ok) begin
                    err <= 1'b1;
                    cnt <= '0;
                end else if (dec_data == last) begin
                    if (cnt != CW'(STABLE_SCANS))
                        cnt <= cnt + 1'b1;
                end else begin
                    last <= dec_data;
                    cnt  <= CW'(1);
                end
            end
        end

        assign stable[i]          = (cnt == CW'(STABLE_SCANS));
        assign candidate[4*i +: 4] = last;
        assign digit_err[i]       = err;
    end

    // Comparing against value means an unchanged word never re-pulses.
    assign publish = (&stable) && (!published || (candidate != value));

    always_ff @(posedge clk) begin
        if (reset) begin
            value       <= '0;
            value_valid <= 1'b0;
            published   <= 1'b0;
        end else begin
            value_valid <= publish;
            if (publish) begin
                value     <= candidate;
                published <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: scans words onto the bus and checks
// published value, pulse count/timing and sticky error flags.
module tb_sevenseg_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  segments;
    logic [3:0]  digit_en;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  digit_err;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int cyc = 0;
    int last_pulse_cyc = -1;
    int d0_cyc = 0;

    sevenseg_capture #(.NDIG(4), .SETTLE(2), .STABLE_SCANS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .segments   (segments),
        .digit_en   (digit_en),
        .value      (value),
        .value_valid(value_valid),
        .digit_err  (digit_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (value_valid === 1'b1) begin
        pulses++;
        last_pulse_cyc = cyc;
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
            4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
            4'h8: return 7'h7F; 4'h9: return 7'h73; 4'hA: return 7'h77; 4'hB: return 7'h1F;
            4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
        endcase
    endfunction

    task automatic dwell(input logic [3:0] en, input logic [6:0] seg, input int n);
        digit_en = en;
        segments = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // raw[d] is the pattern driven on digit d; digits are scanned 3 down to 0.
    task automatic scan_raw(input logic [6:0] r3, r2, r1, r0);
        dwell(4'b1000, r3, 4);
        dwell(4'b0100, r2, 4);
        dwell(4'b0010, r1, 4);
        d0_cyc = cyc;
        dwell(4'b0001, r0, 4);
    endtask

    task automatic scan(input logic [15:0] w);
        scan_raw(enc(w[15:12]), enc(w[11:8]), enc(w[7:4]), enc(w[3:0]));
    endtask

    task automatic idle(input int n);
        dwell(4'b0000, 7'h00, n);
    endtask

    task automatic test_reset();
        int p0;
        reset = 1'b1;
        repeat (3) begin
            segments = 7'($urandom);
            digit_en = 4'($urandom);
            @(posedge clk);
            #1;
        end
        total++; if (value !== 16'h0) begin bad++; $display("FAIL rst_value got=%h exp=0000", value); end
        total++; if (value_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", value_valid); end
        total++; if (digit_err !== 4'h0) begin bad++; $display("FAIL rst_err got=%b exp=0000", digit_err); end
        reset = 1'b0;
        p0 = pulses;
        idle(10);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL rst_idle_pulses got=%0d exp=0", pulses - p0); end
        total++; if (value !== 16'h0 || digit_err !== 4'h0) begin
            bad++; $display("FAIL rst_idle_out got=%h/%b exp=0000/0000", value, digit_err);
        end
    endtask

    task automatic test_publish();
        int p0 = pulses;
        scan(16'h1234);
        scan(16'h1234);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL pub_early got=%0d exp=0", pulses - p0); end
        scan(16'h1234);
        idle(8);
        total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL pub_count got=%0d exp=1", pulses - p0); end
        total++; if (last_pulse_cyc !== d0_cyc + 5) begin
            bad++; $display("FAIL pub_latency got=%0d exp=%0d", last_pulse_cyc, d0_cyc + 5);
        end
        total++; if (value !== 16'h1234) begin bad++; $display("FAIL pub_value got=%h exp=1234", value); end
        p0 = pulses;
        repeat (5) scan(16'h1234);
        idle(8);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL pub_repeat got=%0d exp=0", pulses - p0); end
    endtask

    task automatic test_change();
        int p0 = pulses;
        scan(16'h1834);
        scan(16'h1834);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL chg_early got=%0d exp=0", pulses - p0); end
        total++; if (value !== 16'h1234) begin bad++; $display("FAIL chg_hold got=%h exp=1234", value); end
        scan(16'h1834);
        idle(8);
        total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL chg_count got=%0d exp=1", pulses - p0); end
        total++; if (value !== 16'h1834) begin bad++; $display("FAIL chg_value got=%h exp=1834", value); end
    endtask

    task automatic test_invalid();
        int p0 = pulses;
        scan_raw(enc(4'h1), enc(4'h8), 7'h00, enc(4'h4));
        idle(8);
        total++; if (digit_err !== 4'b0010) begin bad++; $display("FAIL inv_err got=%b exp=0010", digit_err); end
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL inv_pulse got=%0d exp=0", pulses - p0); end
        // Restoring the same digit leaves the word equal to value: no republish.
        repeat (3) scan(16'h1834);
        idle(8);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL inv_same got=%0d exp=0", pulses - p0); end
        // A new digit after the error must again collect three samples.
        scan(16'h1824);
        scan(16'h1824);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL inv_early got=%0d exp=0", pulses - p0); end
        scan(16'h1824);
        idle(8);
        total++; if (pulses - p0 !== 1 || value !== 16'h1824) begin
            bad++; $display("FAIL inv_new got=%0d/%h exp=1/1824", pulses - p0, value);
        end
        total++; if (digit_err !== 4'b0010) begin bad++; $display("FAIL inv_sticky got=%b exp=0010", digit_err); end
    endtask

    task automatic test_glitch();
        int p0 = pulses;
        idle(4);
        dwell(4'b0001, enc(4'hE), 1);
        idle(4);
        dwell(4'b0011, enc(4'hE), 4);
        idle(4);
        total++; if (digit_err !== 4'b0010 || value !== 16'h1824 || pulses - p0 !== 0) begin
            bad++; $display("FAIL gl_state got=%b/%h/%0d exp=0010/1824/0", digit_err, value, pulses - p0);
        end
        // Had a glitch been sampled, digit0 would reach 3 one scan early.
        scan(16'h182E);
        scan(16'h182E);
        idle(8);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL gl_early got=%0d exp=0", pulses - p0); end
        scan(16'h182E);
        idle(8);
        total++; if (pulses - p0 !== 1 || value !== 16'h182E) begin
            bad++; $display("FAIL gl_pub got=%0d/%h exp=1/182e", pulses - p0, value);
        end
    endtask

    task automatic test_reset_mid();
        int p0 = pulses;
        scan(16'h1234);
        scan(16'h1234);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL rm_pulse got=%0d exp=0", pulses - p0); end
        total++; if (value !== 16'h0 || digit_err !== 4'h0) begin
            bad++; $display("FAIL rm_clear got=%h/%b exp=0000/0000", value, digit_err);
        end
        scan(16'h1234);
        scan(16'h1234);
        total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL rm_early got=%0d exp=0", pulses - p0); end
        scan(16'h1234);
        idle(8);
        total++; if (pulses - p0 !== 1 || value !== 16'h1234) begin
            bad++; $display("FAIL rm_pub got=%0d/%h exp=1/1234", pulses - p0, value);
        end
    endtask

    initial begin
        reset = 1'b1;
        segments = 7'h00;
        digit_en = 4'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_publish();
        test_change();
        test_invalid();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
